// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory-wait
// watchdog, plus absorbing HALT and ERR states.
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       link_sel,
    output logic       halted,
    output logic       error,
    output logic [2:0] state
);

    // state | meaning
    // 0 FETCH  | request instruction at PC (when run=1)
    // 1 DECODE | classify opcode, latch it
    // 2 EXEC   | ALU op / branch / jump target
    // 3 MEM    | data load or store at ALU result
    // 4 WB     | register file write
    // 5 HALT   | absorbing, halted=1
    // 6 ERR    | absorbing, error=1
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_HALT  = 7'b1111111;

    localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [6:0]        opc_q, opc_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout;
    logic              count_en;

    function automatic logic known_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            opc_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            wait_q  <= wait_d;
        end
    end

    // mem_ready on the limit cycle takes priority over the timeout
    assign timeout  = (wait_q == WAIT_LIMIT) && !mem_ready;
    assign count_en = ((state_q == S_FETCH) && run) || (state_q == S_MEM);

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        wait_d  = wait_q;
        case (state_q)
            S_FETCH: begin
                if (run) begin
                    if (mem_ready)    state_d = S_DECODE;
                    else if (timeout) state_d = S_ERR;
                end
            end
            S_DECODE: begin
                opc_d = opcode;
                if (opcode == OP_HALT)     state_d = S_HALT;
                else if (known_op(opcode)) state_d = S_EXEC;
                else                       state_d = S_ERR;
            end
            S_EXEC: begin
                case (opc_q)
                    OP_R, OP_I, OP_JAL, OP_JALR: state_d = S_WB;
                    OP_LOAD, OP_STORE:           state_d = S_MEM;
                    OP_BR:                       state_d = S_FETCH;
                    default:                     state_d = S_ERR;
                endcase
            end
            S_MEM: begin
                if (mem_ready)    state_d = (opc_q == OP_STORE) ? S_FETCH : S_WB;
                else if (timeout) state_d = S_ERR;
            end
            S_WB:            state_d = S_FETCH;
            S_HALT, S_ERR:   state_d = state_q;
            default:         state_d = S_ERR;
        endcase

        if (state_d != state_q)         wait_d = '0;
        else if (count_en && !mem_ready) wait_d = wait_q + 1'b1;
    end

    // Controls are gated by rst_n so they drop the instant reset asserts.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_b  = 1'b0;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        link_sel   = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    if (run) begin
                        mem_req = 1'b1;
                        if (mem_ready) begin
                            ir_write = 1'b1;
                            pc_write = 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    alu_src_b = (opc_q == OP_I) || (opc_q == OP_LOAD) ||
                                (opc_q == OP_STORE) || (opc_q == OP_JALR);
                    if ((opc_q == OP_R) || (opc_q == OP_I)) alu_op = 2'b10;
                    else if (opc_q == OP_BR)                alu_op = 2'b01;
                    case (opc_q)
                        OP_BR: begin
                            pc_write = branch_taken;
                            pc_src   = 2'b01;
                        end
                        OP_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = 2'b01;
                        end
                        OP_JALR: begin
                            pc_write = 1'b1;
                            pc_src   = 2'b10;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (opc_q == OP_STORE);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opc_q == OP_LOAD);
                    link_sel   = (opc_q == OP_JAL) || (opc_q == OP_JALR);
                end
                default: ;
            endcase
        end
    end

    assign halted = (state_q == S_HALT);
    assign error  = (state_q == S_ERR);
    assign state  = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the max consecutive mem_ready-low cycles tolerated in FETCH or MEM.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port run  in  1  fetch enable; low holds the FSM in FETCH with no memory request.
REQ-005 SHALL have port opcode  in  7  instruction-register opcode field, valid from DECODE onward.
REQ-006 SHALL have port mem_ready  in  1  memory completion strobe for the current request.
REQ-007 SHALL have port branch_taken  in  1  comparator result, sampled in EXEC.
REQ-008 SHALL have outputs mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src[1:0], alu_src_b, alu_op[1:0], reg_write, mem_to_reg, link_sel, each 1 bit unless a width is given, as datapath controls.
REQ-009 SHALL have outputs halted  out  1  and error  out  1, which are sticky terminal flags, and state  out  3  current state code.

Function
REQ-010 SHALL use state codes FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6; code 7 SHALL go to ERR on the next edge.
REQ-011 SHALL recognise opcodes R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BR=1100011, JAL=1101111, JALR=1100111, HALT=1111111.
REQ-012 SHALL latch the opcode into an internal register on leaving DECODE; EXEC/MEM/WB decode only the latched value.
REQ-013 In FETCH with run=1, SHALL drive mem_req=1, addr_sel=0 (PC), mem_we=0.
REQ-014 SHALL, on a FETCH cycle with mem_req and mem_ready both 1, assert ir_write=1, pc_write=1, pc_src=00 (PC+4) combinationally, then go to DECODE.
REQ-015 In DECODE, SHALL go to HALT for the HALT opcode, to ERR for an unrecognised opcode, and to EXEC otherwise.
REQ-016 In EXEC, SHALL drive alu_src_b=1 for I/LOAD/STORE/JALR and alu_op=10 for R/I, 01 for BR, and 00 otherwise.
REQ-017 In EXEC, SHALL transition as follows: R/I -> WB; LOAD/STORE -> MEM; BR -> FETCH, with pc_write=branch_taken and pc_src=01; JAL -> WB, with pc_write=1 and pc_src=01; JALR -> WB, with pc_write=1 and pc_src=10.
REQ-018 In MEM, SHALL drive mem_req=1, addr_sel=1 (ALU result) and mem_we=1 only for STORE, then go on mem_ready to WB for LOAD or to FETCH for STORE.
REQ-019 In WB, SHALL drive reg_write=1, mem_to_reg=1 only for LOAD and link_sel=1 only for JAL/JALR, then go to FETCH.
REQ-020 All controls not named for a state SHALL be 0 in that state.
REQ-021 SHALL keep a wait counter that increments each FETCH(run=1)/MEM cycle with mem_ready=0, clears on mem_ready=1 or on a state change, and sends the FSM to ERR when it reaches TIMEOUT_CYCLES-1 with mem_ready still 0.
REQ-022 mem_ready arriving in the same cycle the counter hits its limit SHALL win, meaning a normal transition with no error.
REQ-023 run=0 in FETCH SHALL hold the state and the counter with mem_req=0; run SHALL be ignored in all other states, so in-flight instructions complete.
REQ-024 HALT SHALL set halted=1, ERR SHALL set error=1, and both states SHALL be absorbing until reset, with all controls 0.
REQ-025 Latencies with zero memory wait SHALL be 4 cycles for R/I/JAL/JALR, 3 for BR, 4 for STORE and 5 for LOAD, each memory wait cycle adding 1.

Reset
REQ-026 rst_n=0 SHALL force, immediately, state=FETCH, wait counter=0, latched opcode=0, halted=0, error=0 and all controls 0, including mid-operation or mid-memory-wait.
REQ-027 First fetch after deassertion SHALL begin on the first rising edge with rst_n=1 and run=1.

Verification
REQ-028 SHALL cover R-type add, run=1, mem_ready=1 always -> states 0,1,2,4,0; reg_write=1 only in WB; pc_write only in the FETCH cycle.
REQ-029 SHALL cover LOAD with mem_ready low for 3 MEM cycles -> MEM held 4 cycles, addr_sel=1, mem_we=0; WB with mem_to_reg=1; 8 cycles total.
REQ-030 SHALL cover BR with branch_taken=1, then with branch_taken=0 -> pc_write=1 with pc_src=01 in EXEC in the first case, pc_write=0 in the second; back to FETCH after 3 cycles.
REQ-031 SHALL cover a FETCH with mem_ready held 0 and TIMEOUT_CYCLES=16 -> ERR after 16 cycles, error=1 sticky; also mem_ready=1 on cycle 16 -> DECODE, error=0.
REQ-032 SHALL cover the HALT opcode, then opcode 0000000 after a reset -> halted=1 with controls 0 in the first case, error=1 in the second.
REQ-033 SHALL cover rst_n pulsed low asynchronously mid-MEM of a STORE -> mem_req/mem_we drop before the next edge, state=0 and flags clear.
